// File: rtl/tile_requant_drain_if.sv
// Tile/row handshake bundle for tile_requant_drain.
//   master : environment side, which drives the tile and accepts the rows
//   slave  : block side, which captures the tile and drives the rows
// Signals: tile_valid/tile_ready/C_in/shift/relu_en form the tile capture
// handshake. out_valid/out_ready/out_data/out_row/out_last form the row
// stream.
interface tile_requant_drain_if #(
  parameter int ACCW = 32,
  parameter int OW   = 8,
  parameter int ROWS = 4,
  parameter int COLS = 4
);
  localparam int RW = (ROWS > 1) ? $clog2(ROWS) : 1;

  logic                   tile_valid;
  logic                   tile_ready;
  logic signed [ACCW-1:0] C_in [ROWS][COLS];
  logic [4:0]             shift;
  logic                   relu_en;
  logic                   out_valid;
  logic                   out_ready;
  logic [COLS*OW-1:0]     out_data;
  logic [RW-1:0]          out_row;
  logic                   out_last;

  modport master (
    output tile_valid, C_in, shift, relu_en, out_ready,
    input  tile_ready, out_valid, out_data, out_row, out_last
  );

  modport slave (
    input  tile_valid, C_in, shift, relu_en, out_ready,
    output tile_ready, out_valid, out_data, out_row, out_last
  );
endinterface

// File: rtl/tile_requant_drain.sv
// Captures an accumulator tile in one cycle, requantizes every element
// with a rounding arithmetic right shift, an optional ReLU and saturation
// to OW bits, and then streams the tile out one row per handshake.
// Ports:
//   clk, rst_n : clock, asynchronous active-low reset
//   bus        : tile capture and row stream handshakes (slave view)
//   sat_cnt    : running count of saturated elements, sticks at 0xFFFF
//   overrun    : sticky, a tile was offered while a tile was still draining
module tile_requant_drain #(
  parameter int ACCW = 32,
  parameter int OW   = 8,
  parameter int ROWS = 4,
  parameter int COLS = 4
) (
  input  logic                 clk,
  input  logic                 rst_n,
  tile_requant_drain_if.slave  bus,
  output logic [15:0]          sat_cnt,
  output logic                 overrun
);
  localparam int RW = (ROWS > 1) ? $clog2(ROWS) : 1;

  localparam logic [0:0] IDLE  = 1'b0;
  localparam logic [0:0] DRAIN = 1'b1;

  // Saturation bounds in the ACCW+1 bit working width.
  localparam logic signed [ACCW:0] MAXV =
    $signed({{(ACCW-OW+2){1'b0}}, {(OW-1){1'b1}}});
  localparam logic signed [ACCW:0] MINV =
    $signed({{(ACCW-OW+2){1'b1}}, {(OW-1){1'b0}}});
  localparam logic [RW-1:0] LAST_ROW = RW'(ROWS-1);

  // Returns {clipped, value}. ReLU is applied before saturation, so a
  // negative element clamped by ReLU is never counted as clipped.
  function automatic logic [OW:0] requant(
    input logic signed [ACCW-1:0] acc,
    input logic [4:0]             sh,
    input logic                   relu
  );
    logic signed [ACCW:0] ext;
    logic signed [ACCW:0] rnd;
    logic signed [ACCW:0] r;
    logic                 clip;
    logic [OW-1:0]        val;
    ext = {acc[ACCW-1], acc};
    if (sh == 5'd0) begin
      rnd = '0;
    end else begin
      rnd = $signed({{ACCW{1'b0}}, 1'b1} << (sh - 5'd1));
    end
    r = (ext + rnd) >>> sh;
    if (relu && r[ACCW]) begin
      r = '0;
    end else begin
      r = r;
    end
    if (r > MAXV) begin
      clip = 1'b1;
      val  = MAXV[OW-1:0];
    end else if (r < MINV) begin
      clip = 1'b1;
      val  = MINV[OW-1:0];
    end else begin
      clip = 1'b0;
      val  = r[OW-1:0];
    end
    return {clip, val};
  endfunction

  logic [0:0]         state_r;
  logic [RW-1:0]      row_r;
  logic               out_valid_r;
  logic [COLS*OW-1:0] out_data_r;
  logic [COLS*OW-1:0] rows_r [ROWS];
  logic [15:0]        sat_cnt_r;
  logic               overrun_r;

  logic [COLS*OW-1:0] cap_rows_s [ROWS];
  logic [OW:0]        q_s;
  logic [16:0]        clip_sum_s;
  logic [16:0]        sat_sum_s;
  logic [15:0]        sat_nxt_s;

  // Requantize the whole incoming tile and count the clipped elements.
  always_comb begin
    cap_rows_s = '{default: '0};
    clip_sum_s = 17'd0;
    q_s        = '0;
    for (int r = 0; r < ROWS; r++) begin
      for (int c = 0; c < COLS; c++) begin
        q_s = requant(bus.C_in[r][c], bus.shift, bus.relu_en);
        cap_rows_s[r][c*OW +: OW] = q_s[OW-1:0];
        clip_sum_s = clip_sum_s + {16'd0, q_s[OW]};
      end
    end
  end

  // Saturating update of the clip counter.
  always_comb begin
    sat_sum_s = {1'b0, sat_cnt_r} + clip_sum_s;
    if (sat_sum_s > 17'h0FFFF) begin
      sat_nxt_s = 16'hFFFF;
    end else begin
      sat_nxt_s = sat_sum_s[15:0];
    end
  end

  // Capture/drain state machine and the registered row stream.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_r     <= IDLE;
      row_r       <= '0;
      out_valid_r <= 1'b0;
      out_data_r  <= '0;
      rows_r      <= '{default: '0};
      sat_cnt_r   <= 16'd0;
      overrun_r   <= 1'b0;
    end else begin
      case (state_r)
        IDLE: begin
          if (bus.tile_valid) begin
            rows_r      <= cap_rows_s;
            out_data_r  <= cap_rows_s[0];
            row_r       <= '0;
            out_valid_r <= 1'b1;
            sat_cnt_r   <= sat_nxt_s;
            state_r     <= DRAIN;
          end
        end
        DRAIN: begin
          if (bus.tile_valid) begin
            overrun_r <= 1'b1;
          end
          if (bus.out_ready) begin
            if (row_r == LAST_ROW) begin
              out_valid_r <= 1'b0;
              out_data_r  <= '0;
              row_r       <= '0;
              state_r     <= IDLE;
            end else begin
              out_data_r <= rows_r[row_r + RW'(1)];
              row_r      <= row_r + RW'(1);
            end
          end
        end
        default: begin
          state_r     <= IDLE;
          out_valid_r <= 1'b0;
          row_r       <= '0;
        end
      endcase
    end
  end

  assign bus.tile_ready = (state_r == IDLE);
  assign bus.out_valid  = out_valid_r;
  assign bus.out_data   = out_data_r;
  assign bus.out_row    = row_r;
  assign bus.out_last   = (row_r == LAST_ROW) & out_valid_r;
  assign sat_cnt        = sat_cnt_r;
  assign overrun        = overrun_r;
endmodule

// File: tb/tb_tile_requant_drain.sv
// Directed bench for tile_requant_drain: capture latency, row order,
// rounding shift, ReLU, saturation counting, stalls, overrun, mid-drain reset.
module tb_tile_requant_drain;
  logic        clk;
  logic        rst_n;
  logic [15:0] sat_cnt;
  logic        overrun;

  int checks;
  int errors;

  int tile_a [4][4];
  int tile_b [4][4];
  int tile_c [4][4];
  logic [31:0] ea0 [4];
  logic [31:0] ea2 [4];
  logic [31:0] eb  [4];
  logic [31:0] ec  [4];
  logic [15:0] pat;
  int          exp_row;
  logic        hs;

  tile_requant_drain_if #(.ACCW(32), .OW(8), .ROWS(4), .COLS(4)) bus ();

  tile_requant_drain #(.ACCW(32), .OW(8), .ROWS(4), .COLS(4)) dut (
    .clk     (clk),
    .rst_n   (rst_n),
    .bus     (bus),
    .sat_cnt (sat_cnt),
    .overrun (overrun)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  initial begin
    #200000;
    $display("FAIL watchdog: observed timeout, expected $finish");
    $fatal(1, "watchdog");
  end

  function automatic logic [31:0] pk(input int a, input int b, input int c, input int d);
    return {d[7:0], c[7:0], b[7:0], a[7:0]};
  endfunction

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s: observed=%h expected=%h", tag, obs, exp);
    end
  endtask

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  task automatic load(input int t [4][4]);
    for (int r = 0; r < 4; r++)
      for (int c = 0; c < 4; c++)
        bus.C_in[r][c] = t[r][c];
  endtask

  task automatic capture(input logic [4:0] sh, input logic relu);
    bus.shift      = sh;
    bus.relu_en    = relu;
    bus.tile_valid = 1'b1;
    step();
    bus.tile_valid = 1'b0;
  endtask

  // Drain with out_ready held high, checking each row on its own cycle.
  task automatic drain(input string tag, input logic [31:0] e [4]);
    bus.out_ready = 1'b1;
    for (int r = 0; r < 4; r++) begin
      check({tag, "_valid"}, 32'(bus.out_valid), 32'd1);
      check({tag, "_row"},   32'(bus.out_row),   32'(r));
      check({tag, "_data"},  bus.out_data,       e[r]);
      check({tag, "_last"},  32'(bus.out_last),  32'(r == 3));
      step();
    end
    check({tag, "_end_valid"}, 32'(bus.out_valid),  32'd0);
    check({tag, "_end_ready"}, 32'(bus.tile_ready), 32'd1);
  endtask

  initial begin
    checks = 0;
    errors = 0;
    tile_a = '{'{14, 4, 10, 5}, '{-6, 0, 1, 2}, '{7, -7, 100, 3}, '{6, 2, -2, 9}};
    tile_b = '{'{300, -300, 127, -128}, '{128, -129, -127, 0}, '{0, 0, 0, 0}, '{1, -1, 0, 0}};
    tile_c = '{'{-5, -300, 300, 5}, '{0, 0, 0, 0}, '{0, 0, 0, 0}, '{0, 0, 0, 0}};
    ea0[0] = pk(14, 4, 10, 5);   ea0[1] = pk(-6, 0, 1, 2);
    ea0[2] = pk(7, -7, 100, 3);  ea0[3] = pk(6, 2, -2, 9);
    ea2[0] = pk(4, 1, 3, 1);     ea2[1] = pk(-1, 0, 0, 1);
    ea2[2] = pk(2, -2, 25, 1);   ea2[3] = pk(2, 1, 0, 2);
    eb[0]  = pk(127, -128, 127, -128); eb[1] = pk(127, -128, -127, 0);
    eb[2]  = pk(0, 0, 0, 0);     eb[3]  = pk(1, -1, 0, 0);
    ec[0]  = pk(0, 0, 127, 5);   ec[1]  = pk(0, 0, 0, 0);
    ec[2]  = pk(0, 0, 0, 0);     ec[3]  = pk(0, 0, 0, 0);

    bus.tile_valid = 1'b0;
    bus.shift      = 5'd0;
    bus.relu_en    = 1'b0;
    bus.out_ready  = 1'b0;
    load(tile_a);
    rst_n = 1'b0;
    step();
    step();
    check("rst_ready",   32'(bus.tile_ready), 32'd1);
    check("rst_valid",   32'(bus.out_valid),  32'd0);
    check("rst_row",     32'(bus.out_row),    32'd0);
    check("rst_data",    bus.out_data,        32'd0);
    check("rst_sat",     32'(sat_cnt),        32'd0);
    check("rst_overrun", 32'(overrun),        32'd0);
    rst_n = 1'b1;
    step();

    // Plain tile, no shift: one-cycle latency, rows on consecutive cycles.
    capture(5'd0, 1'b0);
    check("s1_ready_low", 32'(bus.tile_ready), 32'd0);
    drain("s1", ea0);
    check("s1_sat", 32'(sat_cnt), 32'd0);

    // Shift 2 with rounding; changing shift/relu mid-drain has no effect.
    capture(5'd2, 1'b0);
    bus.shift   = 5'd0;
    bus.relu_en = 1'b1;
    drain("s2", ea2);

    // Saturation: four clipped elements.
    load(tile_b);
    capture(5'd0, 1'b0);
    check("s3_sat", 32'(sat_cnt), 32'd4);
    drain("s3", eb);

    // ReLU: -5 and -300 become 0 without counting; 300 still clips.
    load(tile_c);
    capture(5'd0, 1'b1);
    check("s4_sat", 32'(sat_cnt), 32'd5);
    drain("s4", ec);

    // Stalled drain with an overrun pulse carrying different data.
    check("s5_overrun_pre", 32'(overrun), 32'd0);
    load(tile_a);
    bus.out_ready = 1'b0;
    capture(5'd0, 1'b0);
    pat = 16'b1010_0110_0001_0010;
    exp_row = 0;
    for (int cyc = 0; cyc < 40 && exp_row < 4; cyc++) begin
      bus.out_ready  = pat[cyc % 16];
      bus.tile_valid = (cyc == 3);
      if (cyc == 3) load(tile_b);
      check("s5_valid", 32'(bus.out_valid), 32'd1);
      check("s5_row",   32'(bus.out_row),   32'(exp_row));
      check("s5_data",  bus.out_data,       ea0[exp_row]);
      check("s5_last",  32'(bus.out_last),  32'(exp_row == 3));
      hs = bus.out_ready;
      step();
      if (hs) exp_row++;
    end
    bus.tile_valid = 1'b0;
    bus.out_ready  = 1'b0;
    check("s5_end_valid", 32'(bus.out_valid), 32'd0);
    check("s5_overrun",   32'(overrun),       32'd1);
    check("s5_sat",       32'(sat_cnt),       32'd5);

    // Reset while row 2 is presented.
    load(tile_a);
    capture(5'd0, 1'b0);
    bus.out_ready = 1'b1;
    step();
    step();
    check("s6_row2", 32'(bus.out_row), 32'd2);
    rst_n = 1'b0;
    #1;
    check("s6_rst_valid",   32'(bus.out_valid),  32'd0);
    check("s6_rst_ready",   32'(bus.tile_ready), 32'd1);
    check("s6_rst_overrun", 32'(overrun),        32'd0);
    step();
    rst_n = 1'b1;
    step();
    check("s6_post_valid", 32'(bus.out_valid),  32'd0);
    check("s6_post_ready", 32'(bus.tile_ready), 32'd1);
    load(tile_b);
    capture(5'd0, 1'b0);
    check("s6_sat", 32'(sat_cnt), 32'd4);
    drain("s6", eb);

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end
endmodule
